// File: rtl/alu_bus_master.sv
// Bus initiator for the memory-mapped integer ALU. It writes the operands and the opcode,
// polls the status register, reads back the 256-bit result and returns it on the response port.
// Optional feature: define ALU_CLEAR_EN to add a CLR write that returns the ALU to idle after each job.
module alu_bus_master #(
    parameter logic [15:0] SRC0_ADDR   = 16'h3000,
    parameter logic [15:0] SRC1_ADDR   = 16'h3001,
    parameter logic [15:0] CTRL_ADDR   = 16'h3E00,
    parameter logic [15:0] STATUS_ADDR = 16'h3F00,
    parameter logic [15:0] RESULT_ADDR = 16'h3D00,
    parameter int unsigned POLL_MAX    = 8
) (
    input  logic         clk,
    input  logic         nReset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [15:0]  req_op,
    input  logic [15:0]  req_a,
    input  logic [15:0]  req_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [255:0] rsp_result,
    output logic         rsp_error,
    output logic [15:0]  address,
    output logic         nRead,
    output logic         nWrite,
    inout  wire  [255:0] dataBus
);

    typedef enum logic [3:0] {
        IDLE, WR_A, WR_B, WR_OP, POLL, RD_RES, TURN,
`ifdef ALU_CLEAR_EN
        CLR,
`endif
        RESP
    } state_t;

    localparam logic [7:0] POLL_LAST = 8'(POLL_MAX - 1);

    // A timed-out poll still needs a turnaround cycle before the CLR write may drive the bus.
`ifdef ALU_CLEAR_EN
    localparam state_t AFTER_TURN = CLR;
    localparam state_t ON_TIMEOUT = TURN;
`else
    localparam state_t AFTER_TURN = RESP;
    localparam state_t ON_TIMEOUT = RESP;
`endif

    state_t      state, next_state;
    logic [15:0] op_q, b_q;
    logic [7:0]  poll_cnt;
    logic        drive_en;
    logic [15:0] wdata;
    logic        accept, poll_miss, poll_timeout;
    logic [15:0] nxt_address, nxt_wdata;
    logic        nxt_nread, nxt_nwrite, nxt_drive;

    assign accept  = req_valid && req_ready;
    assign dataBus = drive_en ? {240'b0, wdata} : {256{1'bz}};

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        next_state   = state;
        poll_miss    = 1'b0;
        poll_timeout = 1'b0;
        case (state)
            IDLE:   if (accept) next_state = WR_A;
            WR_A:   next_state = WR_B;
            WR_B:   next_state = WR_OP;
            WR_OP:  next_state = POLL;
            POLL: begin
                if (dataBus[0]) begin
                    next_state = RD_RES;
                end else begin
                    poll_miss = 1'b1;
                    if (poll_cnt == POLL_LAST) begin
                        poll_timeout = 1'b1;
                        next_state   = ON_TIMEOUT;
                    end
                end
            end
            RD_RES: next_state = TURN;
            TURN:   next_state = AFTER_TURN;
`ifdef ALU_CLEAR_EN
            CLR:    next_state = RESP;
`endif
            RESP:   if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Bus outputs are decoded from the next state so they come straight out of flops.
    always_comb begin
        nxt_address = '0;
        nxt_nread   = 1'b1;
        nxt_nwrite  = 1'b1;
        nxt_drive   = 1'b0;
        nxt_wdata   = '0;
        case (next_state)
            // WR_A is only entered on the accept edge, so the live operand is the one being latched.
            WR_A: begin
                nxt_address = SRC0_ADDR;
                nxt_nwrite  = 1'b0;
                nxt_drive   = 1'b1;
                nxt_wdata   = req_a;
            end
            WR_B: begin
                nxt_address = SRC1_ADDR;
                nxt_nwrite  = 1'b0;
                nxt_drive   = 1'b1;
                nxt_wdata   = b_q;
            end
            WR_OP: begin
                nxt_address = CTRL_ADDR;
                nxt_nwrite  = 1'b0;
                nxt_drive   = 1'b1;
                nxt_wdata   = op_q;
            end
            POLL: begin
                nxt_address = STATUS_ADDR;
                nxt_nread   = 1'b0;
            end
            RD_RES: begin
                nxt_address = RESULT_ADDR;
                nxt_nread   = 1'b0;
            end
`ifdef ALU_CLEAR_EN
            CLR: begin
                nxt_address = CTRL_ADDR;
                nxt_nwrite  = 1'b0;
                nxt_drive   = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state      <= IDLE;
            address    <= '0;
            nRead      <= 1'b1;
            nWrite     <= 1'b1;
            drive_en   <= 1'b0;
            wdata      <= '0;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_error  <= 1'b0;
            poll_cnt   <= '0;
            op_q       <= '0;
            b_q        <= '0;
        end else begin
            state     <= next_state;
            address   <= nxt_address;
            nRead     <= nxt_nread;
            nWrite    <= nxt_nwrite;
            drive_en  <= nxt_drive;
            wdata     <= nxt_wdata;
            req_ready <= (next_state == IDLE);
            rsp_valid <= (next_state == RESP);
            if (accept) begin
                op_q       <= req_op;
                b_q        <= req_b;
                poll_cnt   <= '0;
                rsp_error  <= 1'b0;
                rsp_result <= '0;
            end
            if (poll_miss) poll_cnt <= poll_cnt + 8'd1;
            if (poll_timeout) begin
                rsp_error  <= 1'b1;
                rsp_result <= '0;
            end
            if (state == RD_RES) rsp_result <= dataBus;
        end
    end

endmodule

// File: tb/tb_alu_bus_master.sv
// Self-checking bench for alu_bus_master: a bus-level ALU responder, a job-level reference
// model, a directed vector table, reset corner sequences and randomized jobs.
module tb_alu_bus_master;

    localparam int          POLL_MAX    = 8;
    localparam logic [15:0] SRC0_ADDR   = 16'h3000;
    localparam logic [15:0] SRC1_ADDR   = 16'h3001;
    localparam logic [15:0] CTRL_ADDR   = 16'h3E00;
    localparam logic [15:0] STATUS_ADDR = 16'h3F00;
`ifdef ALU_CLEAR_EN
    localparam int CLR_CYC = 1;
`else
    localparam int CLR_CYC = 0;
`endif

    logic         clk, nReset;
    logic         req_valid, req_ready, rsp_valid, rsp_ready, rsp_error;
    logic         nRead, nWrite;
    logic [15:0]  req_op, req_a, req_b, address;
    logic [255:0] rsp_result;
    wire  [255:0] dataBus;

    int n_checks, n_fail;
    int cyc, poll_total, proto_err, status_delay;
    logic [31:0] wr_log[$];

    typedef struct {
        logic [15:0]  op, a, b;
        int           delay, hold;
        logic [255:0] res;
        logic         err;
        int           polls, lat;
    } vec_t;
    vec_t vecs[5];
    logic [15:0] ops[4] = '{16'h3100, 16'h3200, 16'h3300, 16'h3A5A};

    alu_bus_master #(.POLL_MAX(POLL_MAX)) dut (
        .clk(clk), .nReset(nReset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_error(rsp_error),
        .address(address), .nRead(nRead), .nWrite(nWrite),
        .dataBus(dataBus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- ALU responder ----------------
    function automatic logic known_op(input logic [15:0] op);
        return (op == 16'h3100) || (op == 16'h3200) || (op == 16'h3300);
    endfunction

    function automatic logic [255:0] alu_compute(input logic [15:0] op, input logic [15:0] a,
                                                 input logic [15:0] b);
        case (op)
            16'h3100: return 256'(a) + 256'(b);
            16'h3200: return 256'(a) - 256'(b);
            16'h3300: return 256'(a) * 256'(b);
            default:  return '0;
        endcase
    endfunction

    logic [15:0]  src0, src1, ctrl;
    int           alu_polls;
    logic         resp_en;
    logic [255:0] resp_data;

    initial begin
        src0 = '0; src1 = '0; ctrl = '0; alu_polls = 0; resp_en = 1'b0; resp_data = '0;
    end

    always @(posedge clk) begin
        if (!nWrite) begin
            if (address == SRC0_ADDR) src0 <= dataBus[15:0];
            if (address == SRC1_ADDR) src1 <= dataBus[15:0];
            if (address == CTRL_ADDR) begin
                ctrl      <= dataBus[15:0];
                alu_polls <= 0;
            end
        end else if (!nRead && address[15:8] == 8'h3F) begin
            alu_polls <= alu_polls + 1;
        end
    end

    always @(negedge clk) begin
        resp_en <= !nRead;
        if (!nRead) begin
            if (address[15:8] == 8'h3F)
                resp_data <= {255'b0, known_op(ctrl) && (alu_polls >= status_delay)};
            else if (address[15:8] == 8'h3D)
                resp_data <= alu_compute(ctrl, src0, src1);
            else
                resp_data <= '0;
        end
    end

    assign dataBus = (resp_en && !nRead) ? resp_data : {256{1'bz}};

    // ---------------- bus monitor ----------------
    initial begin
        poll_total = 0;
        proto_err  = 0;
        cyc        = 0;
    end

    always begin
        @(negedge clk);
        #2;
        if (nReset) begin
            if (!nWrite) begin
                wr_log.push_back({address, dataBus[15:0]});
                if (dataBus[255:16] !== '0) proto_err++;
            end
            if (!nRead && address == STATUS_ADDR) poll_total++;
            if (!nRead && !nWrite) proto_err++;
            if (nRead && nWrite && address != 16'h0) proto_err++;
            if (!nRead && $isunknown(dataBus)) proto_err++;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_reset();
        nReset = 1'b0;
        repeat (2) @(negedge clk);
        nReset = 1'b1;
    endtask

    // Job-level reference: what the response and bus activity must look like for one job.
    function automatic void ref_job(input logic [15:0] op, input logic [15:0] a, input logic [15:0] b,
                                    input int delay, output logic [255:0] res, output logic err,
                                    output int polls, output int lat);
        if (!known_op(op) || delay >= POLL_MAX) begin
            res = '0; err = 1'b1; polls = POLL_MAX; lat = -1;
        end else begin
            res = alu_compute(op, a, b); err = 1'b0; polls = delay + 1;
            lat = 5 + polls + CLR_CYC;
        end
    endfunction

    // Runs one job starting at a negedge; returns at a negedge after the response handshake.
    task automatic run_job(input logic [15:0] op, input logic [15:0] a, input logic [15:0] b,
                           input int delay, input int hold,
                           output logic [255:0] res, output logic err, output int lat,
                           output int polls, output int wr_start, output bit ok);
        int t, unstable, accept_cyc, p0;
        ok = 1'b0; res = '0; err = 1'b0; lat = -1; polls = 0; unstable = 0;
        status_delay = delay;
        t = 0;
        while (!req_ready && t < 50) begin @(negedge clk); t++; end
        if (!req_ready) begin
            check("req_ready_wait", 256'(req_ready), 256'd1);
            pulse_reset();
            return;
        end
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        wr_start   = wr_log.size();
        p0         = poll_total;
        accept_cyc = cyc + 1;
        @(negedge clk);
        req_valid = 1'b0;
        req_op = 16'($urandom); req_a = 16'($urandom); req_b = 16'($urandom);
        t = 0;
        while (!rsp_valid && t < 200) begin @(negedge clk); t++; end
        if (!rsp_valid) begin
            check("rsp_valid_wait", 256'(rsp_valid), 256'd1);
            pulse_reset();
            return;
        end
        lat = cyc - accept_cyc;
        res = rsp_result;
        err = rsp_error;
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1; req_op = 16'h3100;
            req_a = 16'($urandom); req_b = 16'($urandom);
            @(negedge clk);
            if (!rsp_valid || rsp_result !== res || rsp_error !== err || req_ready) unstable++;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("hold_stable", 256'(unstable), 256'd0);
        check("handshake", 256'({rsp_valid, req_ready}), 256'(2'b01));
        polls = poll_total - p0;
        ok = 1'b1;
    endtask

    task automatic verify_job(input string tag, input logic [15:0] op, input logic [15:0] a,
                              input logic [15:0] b, input logic [255:0] exp_res, input logic exp_err,
                              input int exp_polls, input int exp_lat, input logic [255:0] res,
                              input logic err, input int lat, input int polls, input int wr_start);
        logic [31:0] exp_wr[$];
        int bad;
        check({tag, "_result"}, res, exp_res);
        check({tag, "_error"}, 256'(err), 256'(exp_err));
        check({tag, "_polls"}, 256'(polls), 256'(exp_polls));
        if (exp_lat >= 0) check({tag, "_latency"}, 256'(lat), 256'(exp_lat));
        exp_wr = '{{SRC0_ADDR, a}, {SRC1_ADDR, b}, {CTRL_ADDR, op}};
`ifdef ALU_CLEAR_EN
        exp_wr.push_back({CTRL_ADDR, 16'h0000});
`endif
        bad = 0;
        if (wr_log.size() - wr_start != exp_wr.size()) bad = 1;
        else
            for (int i = 0; i < exp_wr.size(); i++)
                if (wr_log[wr_start + i] !== exp_wr[i]) bad++;
        check({tag, "_writes"}, 256'(bad), 256'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [255:0] res, e_res;
        logic         err, e_err;
        int           lat, polls, wr_start, e_polls, e_lat, t, p0, spurious;
        bit           ok;
        logic [15:0]  op, a, b;
        int           delay, hold;

        n_checks = 0; n_fail = 0;
        nReset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_op = '0; req_a = '0; req_b = '0; status_delay = 0;

        vecs[0] = '{16'h3100, 16'd5,      16'd7, 0, 0, 256'd12,       1'b0, 1,        6 + CLR_CYC};
        vecs[1] = '{16'h3300, 16'hFFFF,   16'd2, 0, 1, 256'h1FFFE,    1'b0, 1,        6 + CLR_CYC};
        vecs[2] = '{16'h1234, 16'd9,      16'd4, 0, 0, 256'd0,        1'b1, POLL_MAX, -1};
        vecs[3] = '{16'h3200, 16'd10,     16'd3, 3, 0, 256'd7,        1'b0, 4,        9 + CLR_CYC};
        vecs[4] = '{16'h3100, 16'd1,      16'd1, 0, 5, 256'd2,        1'b0, 1,        6 + CLR_CYC};

        #1 nReset = 1'b0;
        #1;
        check("rst_req_ready", 256'(req_ready), 256'd1);
        check("rst_rsp", 256'({rsp_valid, rsp_error}), 256'd0);
        check("rst_result", rsp_result, 256'd0);
        check("rst_bus", 256'({address, nRead, nWrite}), 256'({16'h0, 2'b11}));
        repeat (2) @(negedge clk);
        nReset = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_job(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].delay, vecs[i].hold,
                    res, err, lat, polls, wr_start, ok);
            if (ok) verify_job($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                               vecs[i].res, vecs[i].err, vecs[i].polls, vecs[i].lat,
                               res, err, lat, polls, wr_start);
        end

        // Reset while the master is driving operand A.
        req_op = 16'h3100; req_a = 16'hBEEF; req_b = 16'h0001; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("wra_driving", 256'(dataBus[15:0]), 256'(16'hBEEF));
        #1 nReset = 1'b0;
        #1;
        check("wra_reset_bus_released", 256'($countones(dataBus)), 256'd0);
        check("wra_reset_strobes", 256'({address, nRead, nWrite}), 256'({16'h0, 2'b11}));
        repeat (2) @(negedge clk);
        nReset = 1'b1;

        // Reset in the middle of polling abandons the job without any response.
        status_delay = 100;
        req_op = 16'h3100; req_a = 16'd3; req_b = 16'd4; req_valid = 1'b1;
        p0 = poll_total;
        @(negedge clk);
        req_valid = 1'b0;
        t = 0;
        while (poll_total - p0 < 2 && t < 50) begin @(negedge clk); t++; end
        check("poll_reached", 256'({nRead, address}), 256'({1'b0, STATUS_ADDR}));
        #1 nReset = 1'b0;
        #1;
        check("poll_reset_bus", 256'({address, nRead, nWrite}), 256'({16'h0, 2'b11}));
        check("poll_reset_bus_released", 256'($countones(dataBus)), 256'd0);
        check("poll_reset_ports", 256'({req_ready, rsp_valid, rsp_error}), 256'(3'b100));
        check("poll_reset_result", rsp_result, 256'd0);
        repeat (2) @(negedge clk);
        nReset = 1'b1;
        spurious = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid || !req_ready) spurious++;
        end
        check("poll_reset_no_rsp", 256'(spurious), 256'd0);
        run_job(16'h3100, 16'd1, 16'd1, 0, 0, res, err, lat, polls, wr_start, ok);
        if (ok) verify_job("after_reset", 16'h3100, 16'd1, 16'd1, 256'd2, 1'b0, 1, 6 + CLR_CYC,
                           res, err, lat, polls, wr_start);

        for (int k = 0; k < 20; k++) begin
            op    = ops[$urandom_range(0, 3)];
            a     = 16'($urandom);
            b     = 16'($urandom);
            delay = $urandom_range(0, 9);
            hold  = $urandom_range(0, 3);
            ref_job(op, a, b, delay, e_res, e_err, e_polls, e_lat);
            run_job(op, a, b, delay, hold, res, err, lat, polls, wr_start, ok);
            if (ok) verify_job($sformatf("rnd%0d", k), op, a, b, e_res, e_err, e_polls, e_lat,
                               res, err, lat, polls, wr_start);
        end

        check("protocol", 256'(proto_err), 256'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
